wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline's writeback result and a multi-cycle execution unit (divider/long-latency unit) that returns results out of band. Multi-cycle results are queued in a small FIFO and inserted into free writeback slots; a starvation counter forces a one-cycle pipeline stall when the queue head has waited too long. The block sits after the writeback result mux and directly drives the register-file write port.

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/wb_port_arbiter_if.sv | 27 ++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/wb_port_arbiter.sv | 110 +++++++++++
 tb/tb_wb_port_arbiter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam logic [4:0]  REG_ZERO      = 5'd0;

    typedef struct packed {
        logic [4:0]               rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_MC
    } grant_e;

    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Pipeline writeback, multi-cycle unit and register-file write-port signals.
interface wb_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  pipe_wb_valid;
    logic [4:0]            pipe_rd;
    logic [DATA_WIDTH-1:0] pipe_result;
    logic                  pipe_stall;
    logic                  mc_valid;
    logic                  mc_ready;
    logic [4:0]            mc_rd;
    logic [DATA_WIDTH-1:0] mc_data;
    logic                  rf_we;
    logic [4:0]            rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [31:0]           mc_pending;

    modport slave (
        input  pipe_wb_valid, pipe_rd, pipe_result, mc_valid, mc_rd, mc_data,
        output pipe_stall, mc_ready, rf_we, rf_waddr, rf_wdata, mc_pending
    );

    modport master (
        output pipe_wb_valid, pipe_rd, pipe_result, mc_valid, mc_rd, mc_data,
        input  pipe_stall, mc_ready, rf_we, rf_waddr, rf_wdata, mc_pending
    );
endinterface

// File: rtl/wb_fifo.sv
// Small FIFO of queued multi-cycle results; also reports which registers are pending.
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  wb_req_t       i_req,
    input  logic          i_pop,
    output wb_req_t       o_head,
    output logic [CW-1:0] o_count,
    output logic [31:0]   o_pending
);

    wb_req_t          r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [31:0]      w_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_req;
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_comb begin
        w_pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                w_pending = w_pending | rd_onehot(r_mem[i].rd);
            end
        end
    end

    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;
    assign o_pending = w_pending;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// and queued multi-cycle results, with a starvation-forced pipeline stall.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0]         w_count;
    logic [31:0]           w_pending;
    wb_req_t               w_head;
    wb_req_t               w_push_req;
    logic                  w_empty;
    logic                  w_ready;
    logic                  w_real;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_stall;
    grant_e                w_gnt;

    logic [WW-1:0]         r_wait;
    logic                  r_we;
    logic [4:0]            r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    assign w_empty = (w_count == '0);
    // Readiness comes from the registered count only: a full FIFO never
    // accepts, even in a cycle where it is popping.
    assign w_ready = (w_count < CW'(DEPTH));
    assign w_real  = bus.pipe_wb_valid && (bus.pipe_rd != REG_ZERO);
    assign w_push  = bus.mc_valid && w_ready && (bus.mc_rd != REG_ZERO);
    assign w_push_req = '{rd: bus.mc_rd, data: bus.mc_data};

    always_comb begin
        w_gnt   = GNT_NONE;
        w_stall = 1'b0;
        if (w_empty) begin
            if (w_real) w_gnt = GNT_PIPE;
        end else if (!w_real) begin
            w_gnt = GNT_MC;
        end else if (r_wait < WW'(MAX_WAIT)) begin
            w_gnt = GNT_PIPE;
        end else begin
            w_gnt   = GNT_MC;
            w_stall = 1'b1;
        end
    end

    assign w_pop = (w_gnt == GNT_MC);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_req     (w_push_req),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_pending (w_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if (w_pop || w_empty) begin
            r_wait <= '0;
        end else if (w_gnt == GNT_PIPE && r_wait < WW'(MAX_WAIT)) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            case (w_gnt)
                GNT_PIPE: begin
                    r_we    <= 1'b1;
                    r_waddr <= bus.pipe_rd;
                    r_wdata <= bus.pipe_result;
                end
                GNT_MC: begin
                    r_we    <= 1'b1;
                    r_waddr <= w_head.rd;
                    r_wdata <= w_head.data;
                end
                default: r_we <= 1'b0;
            endcase
        end
    end

    assign bus.pipe_stall = w_stall;
    assign bus.mc_ready   = w_ready;
    assign bus.mc_pending = w_pending;
    assign bus.rf_we      = r_we;
    assign bus.rf_waddr   = r_waddr;
    assign bus.rf_wdata   = r_wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: queue-based reference model predicts
// every register-file write; a monitor compares them as they appear.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    localparam int unsigned DW       = 32;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    wb_port_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wr_t         mq[$];
    wr_t         sb[$];
    int unsigned mwait   = 0;
    int          checks  = 0;
    int          errors  = 0;
    bit          stalled = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check combinational outputs, predict the write.
    task automatic step(input bit v, input logic [4:0] rd, input logic [31:0] res,
                        input bit mv, input logic [4:0] mrd, input logic [31:0] md);
        bit          real_req;
        bit          empty;
        bit          e_ready;
        bit          e_stall;
        logic [31:0] e_pend;
        @(negedge clk);
        bus.pipe_wb_valid = v;
        bus.pipe_rd       = rd;
        bus.pipe_result   = res;
        bus.mc_valid      = mv;
        bus.mc_rd         = mrd;
        bus.mc_data       = md;
        #1;
        real_req = v && (rd != 5'd0);
        empty    = (mq.size() == 0);
        e_ready  = (mq.size() < DEPTH);
        e_stall  = !empty && real_req && (mwait == MAX_WAIT);
        e_pend   = '0;
        foreach (mq[i]) e_pend |= (32'd1 << mq[i].rd);
        chk("mc_ready", {31'd0, bus.mc_ready}, {31'd0, e_ready});
        chk("pipe_stall", {31'd0, bus.pipe_stall}, {31'd0, e_stall});
        chk("mc_pending", bus.mc_pending, e_pend);
        stalled = e_stall;
        if (empty) begin
            if (real_req) sb.push_back('{rd: rd, data: res});
        end else if (!real_req || mwait == MAX_WAIT) begin
            sb.push_back(mq.pop_front());
            mwait = 0;
        end else begin
            sb.push_back('{rd: rd, data: res});
            mwait++;
        end
        if (mv && e_ready && mrd != 5'd0) mq.push_back('{rd: mrd, data: md});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin : monitor
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                chk("rf_we", {31'd0, bus.rf_we}, {31'd0, sb.size() > 0});
                if (bus.rf_we && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, e.rd});
                    chk("rf_wdata", bus.rf_wdata, e.data);
                end
            end
        end
    end

    initial begin : stim
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pres;
        bus.pipe_wb_valid = 0; bus.pipe_rd = '0; bus.pipe_result = '0;
        bus.mc_valid = 0; bus.mc_rd = '0; bus.mc_data = '0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
        chk("rst_mc_ready", {31'd0, bus.mc_ready}, 32'd1);
        rst_n = 1;

        // Pipeline only, then rd=0 which must not write
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        step(1, 5'd0, 32'h11111111, 0, 5'd0, 32'd0);
        idle(2);

        // MC result into idle slots
        step(0, 5'd0, 32'd0, 1, 5'd7, 32'h00001234);
        idle(3);

        // Starvation: one queued entry against continuous pipeline traffic
        step(0, 5'd0, 32'd0, 1, 5'd9, 32'h0000AAAA);
        for (int i = 0; i < 8; i++) step(1, 5'd3, 32'h300 + i, 0, 5'd0, 32'd0);
        idle(2);

        // Fill FIFO under pipeline load, keep offering while full
        for (int i = 0; i < 10; i++)
            step(1, 5'd4, 32'h400 + i, 1, 5'd10 + i[4:0], 32'h1000 + i);
        idle(4);

        // mc_rd=0 transfer: accepted, discarded
        step(0, 5'd0, 32'd0, 1, 5'd0, 32'h55);
        idle(2);

        // Asynchronous reset with queued entries
        step(1, 5'd6, 32'h600, 1, 5'd20, 32'h2000);
        step(1, 5'd6, 32'h601, 1, 5'd21, 32'h2001);
        bus.pipe_wb_valid = 0; bus.mc_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_rf_we", {31'd0, bus.rf_we}, 32'd0);
        chk("arst_rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
        chk("arst_rf_wdata", bus.rf_wdata, 32'd0);
        chk("arst_mc_pending", bus.mc_pending, 32'd0);
        chk("arst_mc_ready", {31'd0, bus.mc_ready}, 32'd1);
        chk("arst_pipe_stall", {31'd0, bus.pipe_stall}, 32'd0);
        mq.delete();
        sb.delete();
        mwait = 0;
        @(negedge clk);
        rst_n = 1;
        idle(3);

        // Randomized traffic; a stalled pipeline request is re-presented
        pv = 0; prd = '0; pres = '0;
        for (int i = 0; i < 800; i++) begin
            if (!stalled) begin
                pv   = ($urandom_range(0, 9) < 7);
                prd  = 5'($urandom_range(0, 31));
                pres = $urandom;
            end
            step(pv, prd, pres, ($urandom_range(0, 9) < 4),
                 5'($urandom_range(0, 31)), $urandom);
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
